// File: rtl/hls_fp32_add_core_chn_o_rsci_skid.sv
// Output-channel transmitter: 2-entry skid buffer between core stores and a valid/ready consumer.
// Latency: a word stored in cycle N is presented on chn_o_rsc_z/chn_o_rsc_lz in cycle N+1.
// Backpressure: core_wten stalls the core only while both entries are occupied; vz never reaches core_wten.
module hls_fp32_add_core_chn_o_rsci_skid #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          chn_o_rsci_oswt,
    input  logic          core_wen,
    input  logic [DW-1:0] chn_o_rsci_d,
    output logic          core_wten,
    output logic [DW-1:0] chn_o_rsc_z,
    output logic          chn_o_rsc_lz,
    input  logic          chn_o_rsc_vz,
    output logic          chn_o_rsci_ovf,
    output logic [CW-1:0] chn_o_rsci_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t          state;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          ovf;
    logic [CW-1:0] cnt;

    logic store;
    logic push;
    logic pop;

    // Accept decision looks only at registered occupancy, so a same-cycle pop never opens a slot.
    assign store = chn_o_rsci_oswt & core_wen;
    assign push  = store & (state != FULL);
    assign pop   = chn_o_rsc_lz & chn_o_rsc_vz;

    assign chn_o_rsc_lz   = (state != EMPTY);
    assign core_wten      = chn_o_rsci_oswt & (state == FULL);
    assign chn_o_rsc_z    = head;
    assign chn_o_rsci_ovf = ovf;
    assign chn_o_rsci_cnt = cnt;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            if (pop) begin
                cnt <= cnt + CW'(1);
            end
            // A store into a full buffer means the core ignored the stall; the word is dropped.
            if (store && (state == FULL)) begin
                ovf <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= chn_o_rsci_d;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        tail  <= chn_o_rsci_d;
                        state <= FULL;
                    end else if (!push && pop) begin
                        state <= EMPTY;
                    end else if (push && pop) begin
                        head <= chn_o_rsci_d;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_fp32_add_core_chn_o_rsci_skid.sv
// Scoreboarded bench: stimulus queues expected words, a negedge monitor checks every delivered word.
module tb_hls_fp32_add_core_chn_o_rsci_skid;

    logic        clk = 1'b0;
    logic        rstn;
    logic        oswt, wen, vz;
    logic [31:0] d;
    logic        wten, lz, ovf;
    logic [31:0] z;
    logic [15:0] cnt;

    logic        oswt4, wen4, vz4;
    logic [31:0] d4;
    logic        wten4, lz4, ovf4;
    logic [31:0] z4;
    logic [3:0]  cnt4;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hls_fp32_add_core_chn_o_rsci_skid #(.DW(32), .CW(16)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .chn_o_rsci_oswt(oswt),
        .core_wen       (wen),
        .chn_o_rsci_d   (d),
        .core_wten      (wten),
        .chn_o_rsc_z    (z),
        .chn_o_rsc_lz   (lz),
        .chn_o_rsc_vz   (vz),
        .chn_o_rsci_ovf (ovf),
        .chn_o_rsci_cnt (cnt)
    );

    hls_fp32_add_core_chn_o_rsci_skid #(.DW(32), .CW(4)) dut4 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .chn_o_rsci_oswt(oswt4),
        .core_wen       (wen4),
        .chn_o_rsci_d   (d4),
        .core_wten      (wten4),
        .chn_o_rsc_z    (z4),
        .chn_o_rsc_lz   (lz4),
        .chn_o_rsc_vz   (vz4),
        .chn_o_rsci_ovf (ovf4),
        .chn_o_rsci_cnt (cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake (lz & vz) must deliver the oldest queued word.
    always @(negedge clk) begin
        if (rstn === 1'b1 && lz === 1'b1 && vz === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%08h expected no word at %0t", z, $time);
            end else begin
                check("pop_data", z, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; oswt = 1'b0; wen = 1'b0; d = '0; vz = 1'b1;
        oswt4 = 1'b0; wen4 = 1'b0; d4 = '0; vz4 = 1'b1;

        // Reset then idle
        step(); step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("idle_lz", {31'b0, lz}, 32'd0);
            check("idle_z", z, 32'd0);
            check("idle_cnt", {16'b0, cnt}, 32'd0);
            check("idle_ovf", {31'b0, ovf}, 32'd0);
            check("idle_wten", {31'b0, wten}, 32'd0);
        end

        // Single word
        step();
        oswt = 1'b1; wen = 1'b1; d = 32'h3F800000;
        @(negedge clk);
        check("single_wten", {31'b0, wten}, 32'd0);
        exp_q.push_back(32'h3F800000);
        step();
        oswt = 1'b0; wen = 1'b0;
        @(negedge clk);
        check("single_lz", {31'b0, lz}, 32'd1);
        check("single_z", z, 32'h3F800000);
        step();
        @(negedge clk);
        check("single_lz_drop", {31'b0, lz}, 32'd0);
        check("single_cnt", {16'b0, cnt}, 32'd1);

        // Backpressure
        step();
        vz = 1'b0; oswt = 1'b1; wen = 1'b1; d = 32'h1;
        @(negedge clk);
        check("bp_wten1", {31'b0, wten}, 32'd0);
        exp_q.push_back(32'h1);
        step();
        d = 32'h2;
        @(negedge clk);
        check("bp_wten2", {31'b0, wten}, 32'd0);
        exp_q.push_back(32'h2);
        step();
        d = 32'h3; wen = 1'b0;
        @(negedge clk);
        check("bp_stall", {31'b0, wten}, 32'd1);
        check("bp_head", z, 32'h1);
        check("bp_lz", {31'b0, lz}, 32'd1);
        step();
        vz = 1'b1;
        @(negedge clk);
        check("bp_stall_hold", {31'b0, wten}, 32'd1);
        step();
        vz = 1'b0; wen = 1'b1;
        @(negedge clk);
        check("bp_release", {31'b0, wten}, 32'd0);
        check("bp_head2", z, 32'h2);
        exp_q.push_back(32'h3);
        step();
        oswt = 1'b0; wen = 1'b0; vz = 1'b1;
        step(); step();
        @(negedge clk);
        check("bp_empty", {31'b0, lz}, 32'd0);
        check("bp_cnt", {16'b0, cnt}, 32'd4);
        check("bp_ovf", {31'b0, ovf}, 32'd0);

        // Streaming: one push and one pop per cycle never fills the buffer
        for (int i = 0; i < 100; i++) begin
            step();
            oswt = 1'b1; wen = 1'b1; d = 32'h100 + i;
            @(negedge clk);
            check("stream_wten", {31'b0, wten}, 32'd0);
            exp_q.push_back(32'h100 + i);
        end
        step();
        oswt = 1'b0; wen = 1'b0;
        step();
        @(negedge clk);
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_cnt", {16'b0, cnt}, 32'd104);

        // Overflow: core ignores the stall
        step();
        vz = 1'b0; oswt = 1'b1; wen = 1'b1; d = 32'hA;
        exp_q.push_back(32'hA);
        step();
        d = 32'hB;
        exp_q.push_back(32'hB);
        step();
        d = 32'hC;
        @(negedge clk);
        check("ovf_stall", {31'b0, wten}, 32'd1);
        step();
        oswt = 1'b0; wen = 1'b0;
        @(negedge clk);
        check("ovf_set", {31'b0, ovf}, 32'd1);
        check("ovf_head", z, 32'hA);
        step();
        vz = 1'b1;
        step(); step();
        @(negedge clk);
        check("ovf_sticky", {31'b0, ovf}, 32'd1);
        check("ovf_empty", {31'b0, lz}, 32'd0);
        check("ovf_cnt", {16'b0, cnt}, 32'd106);
        check("ovf_drained", exp_q.size(), 32'd0);

        // Reset mid-operation while FULL
        step();
        vz = 1'b0; oswt = 1'b1; wen = 1'b1; d = 32'hE;
        step();
        d = 32'hF;
        step();
        oswt = 1'b0; wen = 1'b0;
        @(negedge clk);
        check("rst_full", {31'b0, lz}, 32'd1);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("rst_lz", {31'b0, lz}, 32'd0);
        check("rst_cnt", {16'b0, cnt}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_z", z, 32'd0);
        step();
        vz = 1'b1; oswt = 1'b1; wen = 1'b1; d = 32'h40490FDB;
        @(negedge clk);
        check("rst_push_wten", {31'b0, wten}, 32'd0);
        exp_q.push_back(32'h40490FDB);
        step();
        oswt = 1'b0; wen = 1'b0;
        @(negedge clk);
        check("rst_push_z", z, 32'h40490FDB);
        step();
        @(negedge clk);
        check("rst_push_cnt", {16'b0, cnt}, 32'd1);
        check("final_drained", exp_q.size(), 32'd0);

        // Counter wrap on a 4-bit counter: 17 deliveries leave cnt at 1
        for (int i = 0; i < 17; i++) begin
            step();
            oswt4 = 1'b1; wen4 = 1'b1; d4 = i;
        end
        step();
        oswt4 = 1'b0; wen4 = 1'b0;
        step();
        @(negedge clk);
        check("wrap_cnt", {28'b0, cnt4}, 32'd1);
        check("wrap_lz", {31'b0, lz4}, 32'd0);
        check("wrap_ovf", {31'b0, ovf4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
